xcfi_trace_emitter: RTL

XCFI_TRACE_EMITTER -- requirements
Module: xcfi_trace_emitter

---
 rtl/xcfi_pkg.sv | 24 ++
 rtl/xcfi_memq.sv | 95 +++++++++
 rtl/xcfi_trace_emitter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/xcfi_pkg.sv
// Shared types for the XCFI trace emitter: default widths, memory-record layout, FSM state.
// Latency: n/a (types only).
// Backpressure: n/a.
package xcfi_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ILEN_DEF       = 32;
    localparam int MEMQ_DEPTH_DEF = 2;

    // Emitter run state: HALTED is terminal until reset
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } trace_state_t;

    // Memory-stage access record captured ahead of retirement (default width)
    typedef struct packed {
        logic [XLEN_DEF-1:0]   addr;
        logic [XLEN_DEF/8-1:0] rmask;
        logic [XLEN_DEF/8-1:0] wmask;
        logic [XLEN_DEF-1:0]   wdata;
    } mem_rec_t;

endpackage

// File: rtl/xcfi_memq.sv
// In-order buffer of memory access records; load data is filled in later, oldest-unfilled first.
// Latency: push/fill/pop visible the cycle after; head is read combinationally.
// Backpressure: none; caller must not push when full without a same-cycle pop.
module xcfi_memq
    import xcfi_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  DEPTH = MEMQ_DEPTH_DEF,   // power of two, at least 2
    parameter type rec_t = mem_rec_t
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  rec_t            push_rec,
    input  logic            push_filled,     // store-only records expect no response
    input  logic            fill,
    input  logic [XLEN-1:0] fill_rdata,
    input  logic            pop,
    input  logic            flush,
    output logic            full,
    output logic            empty,
    output rec_t            head_rec,
    output logic [XLEN-1:0] head_rdata,
    output logic            head_filled
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rec_t            recs  [DEPTH];
    logic [XLEN-1:0] rdata [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]   head;
    logic [CW-1:0]   count;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   fill_idx;
    logic            fill_hit;
    logic            fill_en;

    assign tail        = head + count[PW-1:0];
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign head_rec    = recs[head];
    assign head_rdata  = rdata[head];
    assign head_filled = filled[head];

    // Locate the oldest occupied entry still waiting for its load data
    always_comb begin
        logic [PW-1:0] idx;
        fill_hit = 1'b0;
        fill_idx = head;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (!fill_hit && (CW'(i) < count) && !filled[idx]) begin
                fill_hit = 1'b1;
                fill_idx = idx;
            end
        end
    end

    // A response aimed at the head being popped is consumed by the pop path instead
    assign fill_en = fill && fill_hit && !(pop && (fill_idx == head));

    // Occupancy pointers; flush empties everything that is not leaving this cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (flush) begin
                count <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Entry storage; push is written last so a reused slot always takes the new record
    always_ff @(posedge clk) begin
        if (fill_en) begin
            rdata[fill_idx]  <= fill_rdata;
            filled[fill_idx] <= 1'b1;
        end
        if (push) begin
            recs[tail]   <= push_rec;
            rdata[tail]  <= '0;
            filled[tail] <= push_filled;
        end
    end

endmodule

// File: rtl/xcfi_trace_emitter.sv
// Turns core retire events plus buffered memory records into a registered single-channel RVFI trace.
// Latency: one cycle from ret_valid to rvfi_valid.
// Backpressure: none; protocol violations are flagged on the sticky trace_err instead.
module xcfi_trace_emitter
    import xcfi_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ILEN       = ILEN_DEF,
    parameter int MEMQ_DEPTH = MEMQ_DEPTH_DEF
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              mem_cap_valid,
    input  logic [XLEN-1:0]   mem_cap_addr,
    input  logic [XLEN/8-1:0] mem_cap_rmask,
    input  logic [XLEN/8-1:0] mem_cap_wmask,
    input  logic [XLEN-1:0]   mem_cap_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              ret_valid,
    input  logic [ILEN-1:0]   ret_insn,
    input  logic [XLEN-1:0]   ret_pc,
    input  logic [XLEN-1:0]   ret_npc,
    input  logic              ret_trap,
    input  logic              ret_halt,
    input  logic              ret_mem,
    input  logic [4:0]        ret_rs1_addr,
    input  logic [4:0]        ret_rs2_addr,
    input  logic [4:0]        ret_rs3_addr,
    input  logic [XLEN-1:0]   ret_rs1_rdata,
    input  logic [XLEN-1:0]   ret_rs2_rdata,
    input  logic [XLEN-1:0]   ret_rs3_rdata,
    input  logic [4:0]        ret_rd_addr,
    input  logic [XLEN-1:0]   ret_rd_wdata,
    input  logic              ret_rd_wide,
    input  logic [XLEN-1:0]   ret_rd_wdatahi,
    input  logic              trap_entry,
    input  logic              flush,
    output logic              rvfi_valid,
    output logic [63:0]       rvfi_order,
    output logic [ILEN-1:0]   rvfi_insn,
    output logic              rvfi_trap,
    output logic              rvfi_halt,
    output logic              rvfi_intr,
    output logic [4:0]        rvfi_rs1_addr,
    output logic [4:0]        rvfi_rs2_addr,
    output logic [4:0]        rvfi_rs3_addr,
    output logic [XLEN-1:0]   rvfi_rs1_rdata,
    output logic [XLEN-1:0]   rvfi_rs2_rdata,
    output logic [XLEN-1:0]   rvfi_rs3_rdata,
    output logic [4:0]        rvfi_rd_addr,
    output logic              rvfi_rd_wide,
    output logic [XLEN-1:0]   rvfi_rd_wdata,
    output logic [XLEN-1:0]   rvfi_rd_wdatahi,
    output logic [XLEN-1:0]   rvfi_pc_rdata,
    output logic [XLEN-1:0]   rvfi_pc_wdata,
    output logic [XLEN-1:0]   rvfi_mem_addr,
    output logic [XLEN/8-1:0] rvfi_mem_rmask,
    output logic [XLEN/8-1:0] rvfi_mem_wmask,
    output logic [XLEN-1:0]   rvfi_mem_rdata,
    output logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic              trace_err
);

    // Same layout as mem_rec_t, sized to this instance's XLEN
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN/8-1:0] rmask;
        logic [XLEN/8-1:0] wmask;
        logic [XLEN-1:0]   wdata;
    } rec_t;

    trace_state_t    state;
    logic            intr_pend;
    logic [63:0]     order_cnt;
    rec_t            cap_rec;
    rec_t            head_rec;
    logic [XLEN-1:0] head_rdata;
    logic            head_filled, full, empty;
    logic            retire, halt_err, want_pop, pop, fill, mem_ok;
    logic            push, push_err, pop_err, rd_keep;
    logic [XLEN-1:0] mem_rdata;

    assign cap_rec  = '{addr: mem_cap_addr, rmask: mem_cap_rmask,
                        wmask: mem_cap_wmask, wdata: mem_cap_wdata};

    assign retire   = ret_valid && (state == ST_RUN);
    assign halt_err = ret_valid && (state == ST_HALTED);
    assign want_pop = retire && ret_mem;
    assign pop      = want_pop && !empty;
    // Flush squashes any response arriving alongside it
    assign fill     = mem_rsp_valid && !flush;
    // An unfilled head can still be emitted if its response lands this very cycle
    assign mem_ok   = pop && (head_filled || fill);
    assign mem_rdata = head_filled ? head_rdata : mem_rsp_rdata;
    assign push     = mem_cap_valid && !flush && (!full || pop);
    assign push_err = mem_cap_valid && !flush && full && !pop;
    assign pop_err  = want_pop && !mem_ok;
    assign rd_keep  = !ret_trap && (ret_rd_addr != 5'd0);

    xcfi_memq #(
        .XLEN  (XLEN),
        .DEPTH (MEMQ_DEPTH),
        .rec_t (rec_t)
    ) u_memq (
        .clk         (g_clk),
        .resetn      (g_resetn),
        .push        (push),
        .push_rec    (cap_rec),
        .push_filled (mem_cap_rmask == '0),
        .fill        (fill),
        .fill_rdata  (mem_rsp_rdata),
        .pop         (pop),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .head_rec    (head_rec),
        .head_rdata  (head_rdata),
        .head_filled (head_filled)
    );

    // Run/halt FSM with the registered RVFI record, order counter, intr flag and error flag
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state           <= ST_RUN;
            intr_pend       <= 1'b0;
            trace_err       <= 1'b0;
            order_cnt       <= '0;
            rvfi_valid      <= 1'b0;
            rvfi_order      <= '0;
            rvfi_insn       <= '0;
            rvfi_trap       <= 1'b0;
            rvfi_halt       <= 1'b0;
            rvfi_intr       <= 1'b0;
            rvfi_rs1_addr   <= '0;
            rvfi_rs2_addr   <= '0;
            rvfi_rs3_addr   <= '0;
            rvfi_rs1_rdata  <= '0;
            rvfi_rs2_rdata  <= '0;
            rvfi_rs3_rdata  <= '0;
            rvfi_rd_addr    <= '0;
            rvfi_rd_wide    <= 1'b0;
            rvfi_rd_wdata   <= '0;
            rvfi_rd_wdatahi <= '0;
            rvfi_pc_rdata   <= '0;
            rvfi_pc_wdata   <= '0;
            rvfi_mem_addr   <= '0;
            rvfi_mem_rmask  <= '0;
            rvfi_mem_wmask  <= '0;
            rvfi_mem_rdata  <= '0;
            rvfi_mem_wdata  <= '0;
        end else begin
            rvfi_valid <= retire;
            if (retire) begin
                rvfi_order      <= order_cnt;
                order_cnt       <= order_cnt + 64'd1;
                rvfi_insn       <= ret_insn;
                rvfi_trap       <= ret_trap;
                rvfi_halt       <= ret_halt;
                rvfi_intr       <= intr_pend;
                rvfi_pc_rdata   <= ret_pc;
                rvfi_pc_wdata   <= ret_npc;
                rvfi_rs1_addr   <= ret_rs1_addr;
                rvfi_rs2_addr   <= ret_rs2_addr;
                rvfi_rs3_addr   <= ret_rs3_addr;
                rvfi_rs1_rdata  <= (ret_rs1_addr == 5'd0) ? '0 : ret_rs1_rdata;
                rvfi_rs2_rdata  <= (ret_rs2_addr == 5'd0) ? '0 : ret_rs2_rdata;
                rvfi_rs3_rdata  <= (ret_rs3_addr == 5'd0) ? '0 : ret_rs3_rdata;
                rvfi_rd_addr    <= ret_trap ? 5'd0 : ret_rd_addr;
                rvfi_rd_wide    <= rd_keep && ret_rd_wide;
                rvfi_rd_wdata   <= rd_keep ? ret_rd_wdata : '0;
                rvfi_rd_wdatahi <= rd_keep ? ret_rd_wdatahi : '0;
                rvfi_mem_addr   <= mem_ok ? head_rec.addr : '0;
                rvfi_mem_rmask  <= mem_ok ? head_rec.rmask : '0;
                rvfi_mem_wmask  <= (mem_ok && !ret_trap) ? head_rec.wmask : '0;
                rvfi_mem_wdata  <= mem_ok ? head_rec.wdata : '0;
                rvfi_mem_rdata  <= mem_ok ? mem_rdata : '0;
                if (ret_halt) begin
                    state <= ST_HALTED;
                end
            end
            // A trap_entry alongside a retire is held for the retire after it
            intr_pend <= (intr_pend && !retire) || trap_entry;
            if (push_err || pop_err || halt_err) begin
                trace_err <= 1'b1;
            end
        end
    end

endmodule
